// File: rtl/video_out_pkg.sv
// Shared constants, pixel type and region decode for the video output stage.
package video_out_pkg;

  localparam int H_TOTAL      = 1280 + 110 + 40 + 220;
  localparam int V_TOTAL      = 720 + 5 + 5 + 20;
  localparam int PIX_PER_WORD = 4;
  localparam int PIX_STRIDE   = 32;

  typedef logic [23:0] pix_t;

  // Returns {in_active, in_sync} for a counter position within one axis.
  function automatic logic [1:0] region_decode(input logic [15:0] cnt,
                                               input logic [15:0] active,
                                               input logic [15:0] fp,
                                               input logic [15:0] sync);
    logic de;
    logic sy;
    de = (cnt < active);
    sy = (cnt >= active + fp) && (cnt < active + fp + sync);
    return {de, sy};
  endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// Horizontal/vertical raster counters with frame-boundary run control and region decode.
module video_timing_cnt
  import video_out_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic de_c,
  output logic hs,
  output logic vs,
  output logic sof,
  output logic run
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_SOF  = VW'(V_ACTIVE + V_FP);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          running;
  logic          at_origin;
  logic [1:0]    h_reg;
  logic [1:0]    v_reg;

  // enable only takes effect at the frame origin; elsewhere the stored state holds,
  // so a stopped raster parks both counters at 0.
  assign at_origin = (h_cnt == '0) && (v_cnt == '0);
  assign run       = at_origin ? enable : running;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      running <= 1'b0;
    end else begin
      running <= run;
      if (run) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  assign h_reg = region_decode(16'(h_cnt), 16'(H_ACTIVE), 16'(H_FP), 16'(H_SYNC));
  assign v_reg = region_decode(16'(v_cnt), 16'(V_ACTIVE), 16'(V_FP), 16'(V_SYNC));

  assign de_c = h_reg[1] & v_reg[1] & run;
  assign hs   = h_reg[0];
  assign vs   = v_reg[0];
  assign sof  = run && (h_cnt == '0) && (v_cnt == V_SOF);

endmodule

// File: rtl/video_out_timing.sv
// Raster output stage: unpacks 4-pixel FIFO words onto a timed video bus.
module video_out_timing
  import video_out_pkg::*;
#(
  parameter int   H_ACTIVE   = 1280,
  parameter int   H_FP       = 110,
  parameter int   H_SYNC     = 40,
  parameter int   H_BP       = 220,
  parameter int   V_ACTIVE   = 720,
  parameter int   V_FP       = 5,
  parameter int   V_SYNC     = 5,
  parameter int   V_BP       = 20,
  parameter pix_t FILL_COLOR = 24'h000000,
  parameter int   DATA_WIDTH = 128
) (
  input  logic                  video_clk,
  input  logic                  video_rst,
  input  logic                  enable,
  input  logic                  fifo_rd_valid,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  frame_start,
  output logic                  video_vsync,
  output logic                  video_href,
  output logic                  video_de,
  output logic [23:0]           video_data,
  output logic                  underflow
);

  logic de_c;
  logic hs;
  logic vs;
  logic sof;
  logic run;

  video_timing_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_cnt (
    .clk    (video_clk),
    .rst    (video_rst),
    .enable (enable),
    .de_c   (de_c),
    .hs     (hs),
    .vs     (vs),
    .sof    (sof),
    .run    (run)
  );

  logic [1:0] pix_sel_p0;
  logic       word_ok_p0;
  logic       word_ok_c;
  pix_t       pix_c;

  // The slot's go/no-go is decided by FIFO validity on its first pixel only.
  assign word_ok_c = (pix_sel_p0 == 2'd0) ? fifo_rd_valid : word_ok_p0;

  always_comb begin
    pix_c = '0;
    if (de_c) begin
      pix_c = word_ok_c ? fifo_rd_data[{pix_sel_p0, 5'd0} +: 24] : FILL_COLOR;
    end
  end

  assign fifo_rd_en = de_c & (pix_sel_p0 == 2'd3) & word_ok_p0 & ~video_rst;

  // Stage p0 -> registered video outputs
  always_ff @(posedge video_clk) begin
    if (video_rst) begin
      pix_sel_p0  <= 2'd0;
      word_ok_p0  <= 1'b0;
      underflow   <= 1'b0;
      video_de    <= 1'b0;
      video_href  <= 1'b0;
      video_vsync <= 1'b0;
      frame_start <= 1'b0;
      video_data  <= '0;
    end else begin
      pix_sel_p0 <= de_c ? pix_sel_p0 + 2'd1 : 2'd0;
      if (de_c && (pix_sel_p0 == 2'd0)) begin
        word_ok_p0 <= fifo_rd_valid;
        if (!fifo_rd_valid) underflow <= 1'b1;
      end
      video_de    <= de_c;
      video_href  <= hs & run;
      video_vsync <= vs & run;
      frame_start <= sof;
      video_data  <= pix_c;
    end
  end

endmodule

// File: tb/tb_video_out_timing.sv
// Scoreboard bench for video_out_timing on a reduced 14x7 raster.
module tb_video_out_timing;

  localparam int HA = 8, HFP = 2, HS = 2, HBP = 2;
  localparam int VA = 4, VFP = 1, VS = 1, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam logic [23:0] FILL = 24'h5A5A5A;

  logic         video_clk = 1'b0;
  logic         video_rst = 1'b1;
  logic         enable = 1'b0;
  logic         fifo_rd_valid = 1'b0;
  logic [127:0] fifo_rd_data = '0;
  logic         fifo_rd_en;
  logic         frame_start;
  logic         video_vsync;
  logic         video_href;
  logic         video_de;
  logic [23:0]  video_data;
  logic         underflow;

  always #5 video_clk = ~video_clk;

  video_out_timing #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .FILL_COLOR(FILL), .DATA_WIDTH(128)
  ) dut (
    .video_clk     (video_clk),
    .video_rst     (video_rst),
    .enable        (enable),
    .fifo_rd_valid (fifo_rd_valid),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_en    (fifo_rd_en),
    .frame_start   (frame_start),
    .video_vsync   (video_vsync),
    .video_href    (video_href),
    .video_de      (video_de),
    .video_data    (video_data),
    .underflow     (underflow)
  );

  typedef struct packed {
    logic        rd_en;
    logic        de;
    logic        href;
    logic        vsync;
    logic        fs;
    logic        uf;
    logic [23:0] data;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         exp_prev;
  bit           have_prev = 0;
  logic [127:0] fifo_q[$];
  int           word_seq = 0;
  bit           valid_allow = 1;
  int           total = 0;
  int           bad = 0;

  int m_h = 0, m_v = 0;
  bit m_run = 0, m_wok = 0, m_uf = 0;

  bit          last_pop;
  logic        obs_de, obs_href, obs_vs, obs_fs, obs_uf;
  logic [23:0] obs_data;

  function automatic logic [127:0] mk_word(input int n);
    logic [127:0] w;
    for (int i = 0; i < 4; i++) w[32*i +: 32] = {8'hEE, 24'h100000 + 24'(4*n + i)};
    return w;
  endfunction

  // Per-cycle compare of the combinational pop and the previous edge's registered outputs.
  always @(negedge video_clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (fifo_rd_en !== e.rd_en) begin
        bad++; $display("FAIL sb_rd_en t=%0t got=%b exp=%b", $time, fifo_rd_en, e.rd_en);
      end
      if (have_prev) begin
        total++;
        if (video_de !== exp_prev.de) begin
          bad++; $display("FAIL sb_de t=%0t got=%b exp=%b", $time, video_de, exp_prev.de);
        end
        total++;
        if (video_data !== exp_prev.data) begin
          bad++; $display("FAIL sb_data t=%0t got=%h exp=%h", $time, video_data, exp_prev.data);
        end
        total++;
        if ({video_href, video_vsync, frame_start, underflow} !==
            {exp_prev.href, exp_prev.vsync, exp_prev.fs, exp_prev.uf}) begin
          bad++; $display("FAIL sb_ctrl t=%0t got=%b exp=%b", $time,
                          {video_href, video_vsync, frame_start, underflow},
                          {exp_prev.href, exp_prev.vsync, exp_prev.fs, exp_prev.uf});
        end
      end
      exp_prev  = e;
      have_prev = 1;
    end
  end

  // Drives one clock of stimulus, pushes the reference expectation, serves FIFO pops.
  task automatic cycle(input logic rst_i, input logic en_i);
    exp_t e;
    logic [127:0] d;
    bit origin, run, de, ok, vld;
    int p;
    while (fifo_q.size() < 4) begin
      fifo_q.push_back(mk_word(word_seq));
      word_seq++;
    end
    d   = fifo_q[0];
    vld = valid_allow;
    video_rst     = rst_i;
    enable        = en_i;
    fifo_rd_valid = vld;
    fifo_rd_data  = d;
    e = '0;
    if (rst_i) begin
      m_h = 0; m_v = 0; m_run = 0; m_wok = 0; m_uf = 0;
    end else begin
      origin  = (m_h == 0) && (m_v == 0);
      run     = origin ? en_i : m_run;
      de      = run && (m_h < HA) && (m_v < VA);
      p       = m_h % 4;
      ok      = (p == 0) ? vld : m_wok;
      e.rd_en = de && (p == 3) && m_wok;
      e.de    = de;
      e.href  = run && (m_h >= HA + HFP) && (m_h < HA + HFP + HS);
      e.vsync = run && (m_v >= VA + VFP) && (m_v < VA + VFP + VS);
      e.fs    = run && (m_h == 0) && (m_v == VA + VFP);
      e.data  = !de ? 24'h0 : (ok ? d[32*p +: 24] : FILL);
      if (de && p == 0) begin
        m_wok = vld;
        if (!vld) m_uf = 1;
      end
      e.uf  = m_uf;
      m_run = run;
      if (run) begin
        m_h++;
        if (m_h == HT) begin
          m_h = 0;
          m_v++;
          if (m_v == VT) m_v = 0;
        end
      end
    end
    exp_q.push_back(e);
    #1;
    last_pop = fifo_rd_en;
    @(posedge video_clk);
    #1;
    if (last_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
    obs_de = video_de; obs_href = video_href; obs_vs = video_vsync;
    obs_fs = frame_start; obs_uf = underflow; obs_data = video_data;
  endtask

  task automatic fresh();
    fifo_q.delete();
    word_seq    = 0;
    valid_allow = 1;
  endtask

  task automatic test_reset();
    int nz, pops;
    fresh();
    cycle(1, 0);
    cycle(1, 0);
    total++;
    if ({obs_de, obs_href, obs_vs, obs_fs, obs_uf, obs_data} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%b/%h exp=0", {obs_de, obs_href, obs_vs, obs_fs, obs_uf}, obs_data);
    end
    nz = 0; pops = 0;
    for (int k = 0; k < 6; k++) begin
      cycle(0, 0);
      if ({obs_de, obs_href, obs_vs, obs_fs, obs_data} != '0) nz++;
      if (last_pop) pops++;
    end
    total++;
    if (nz + pops != 0) begin
      bad++; $display("FAIL idle_quiet got nonzero=%0d pops=%0d exp=0", nz, pops);
    end
  endtask

  task automatic test_known_word();
    logic [23:0] want[4];
    logic [23:0] got[4];
    bit          pop[4];
    want[0] = 24'h999999; want[1] = 24'hAAAAAA; want[2] = 24'hBBBBBB; want[3] = 24'hCCCCCC;
    fresh();
    fifo_q.push_back(128'h00CCCCCC_00BBBBBB_00AAAAAA_00999999);
    cycle(1, 1);
    for (int k = 0; k < 4; k++) begin
      cycle(0, 1);
      got[k] = obs_data;
      pop[k] = last_pop;
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (got[k] !== want[k]) begin
        bad++; $display("FAIL known_pix%0d got=%h exp=%h", k, got[k], want[k]);
      end
    end
    total++;
    if ({pop[0], pop[1], pop[2], pop[3]} !== 4'b0001) begin
      bad++; $display("FAIL known_pop got=%b exp=0001", {pop[0], pop[1], pop[2], pop[3]});
    end
  endtask

  task automatic test_raster();
    int n_de, n_href, n_vs, n_pop, n_fs, first_href;
    logic [127:0] w;
    fresh();
    cycle(1, 1);
    n_de = 0; n_href = 0; n_vs = 0; n_pop = 0; n_fs = 0; first_href = -1;
    for (int k = 0; k < FRAME; k++) begin
      cycle(0, 1);
      if (k < HA) begin
        w = mk_word(k / 4);
        total++;
        if (obs_data !== w[32*(k%4) +: 24]) begin
          bad++; $display("FAIL raster_pix%0d got=%h exp=%h", k, obs_data, w[32*(k%4) +: 24]);
        end
      end
      if (obs_href && first_href < 0) first_href = k;
      n_de += int'(obs_de); n_href += int'(obs_href); n_vs += int'(obs_vs);
      n_fs += int'(obs_fs); n_pop += int'(last_pop);
    end
    total++;
    if (n_de != VA * HA) begin bad++; $display("FAIL raster_de got=%0d exp=%0d", n_de, VA * HA); end
    total++;
    if (n_href != VT * HS) begin bad++; $display("FAIL raster_href got=%0d exp=%0d", n_href, VT * HS); end
    total++;
    if (first_href != HA + HFP) begin bad++; $display("FAIL href_pos got=%0d exp=%0d", first_href, HA + HFP); end
    total++;
    if (n_vs != VS * HT) begin bad++; $display("FAIL raster_vs got=%0d exp=%0d", n_vs, VS * HT); end
    total++;
    if (n_pop != VA * HA / 4) begin bad++; $display("FAIL raster_pops got=%0d exp=%0d", n_pop, VA * HA / 4); end
    total++;
    if (n_fs != 1) begin bad++; $display("FAIL raster_fs got=%0d exp=1", n_fs); end
  endtask

  task automatic test_underflow();
    int pops0;
    logic [127:0] w1;
    fresh();
    w1 = mk_word(1);
    cycle(1, 1);
    pops0 = 0;
    for (int k = 0; k < FRAME; k++) begin
      valid_allow = !(k >= 4 && k <= 7);
      cycle(0, 1);
      if (k < HT) pops0 += int'(last_pop);
      if (k >= 4 && k <= 7) begin
        total++;
        if (obs_data !== FILL) begin bad++; $display("FAIL uf_fill%0d got=%h exp=%h", k, obs_data, FILL); end
      end
      if (k == 7) begin
        total++;
        if (obs_uf !== 1'b1) begin bad++; $display("FAIL uf_set got=%b exp=1", obs_uf); end
      end
      if (k == HT) begin
        total++;
        if (obs_data !== w1[23:0]) begin bad++; $display("FAIL uf_resume got=%h exp=%h", obs_data, w1[23:0]); end
      end
    end
    valid_allow = 1;
    total++;
    if (pops0 != 1) begin bad++; $display("FAIL uf_pops got=%0d exp=1", pops0); end
    total++;
    if (obs_uf !== 1'b1) begin bad++; $display("FAIL uf_sticky got=%b exp=1", obs_uf); end
  endtask

  task automatic test_enable_stop();
    int n_de, nz;
    logic [23:0] head;
    fresh();
    cycle(1, 1);
    for (int k = 0; k < 40; k++) cycle(0, 1);
    n_de = 0;
    for (int k = 40; k < FRAME; k++) begin
      cycle(0, 0);
      n_de += int'(obs_de);
    end
    total++;
    if (n_de != HA) begin bad++; $display("FAIL stop_tail_de got=%0d exp=%0d", n_de, HA); end
    nz = 0;
    for (int k = 0; k < 20; k++) begin
      cycle(0, 0);
      if ({obs_de, obs_href, obs_vs, obs_fs, obs_data, last_pop} != '0) nz++;
    end
    total++;
    if (nz != 0) begin bad++; $display("FAIL stop_quiet got=%0d exp=0", nz); end
    head = fifo_q[0][23:0];
    cycle(0, 1);
    total++;
    if ({obs_de, obs_data} !== {1'b1, head}) begin
      bad++; $display("FAIL restart got=%b/%h exp=1/%h", obs_de, obs_data, head);
    end
    for (int k = 1; k < HT; k++) cycle(0, 1);
  endtask

  task automatic test_mid_reset();
    logic [23:0] head;
    fresh();
    cycle(1, 1);
    for (int k = 0; k < 7; k++) cycle(0, 1);
    cycle(1, 1);
    total++;
    if (last_pop !== 1'b0) begin bad++; $display("FAIL rst_pop got=%b exp=0", last_pop); end
    total++;
    if ({obs_de, obs_href, obs_vs, obs_fs, obs_uf, obs_data} !== '0) begin
      bad++; $display("FAIL rst_outputs got=%b/%h exp=0", {obs_de, obs_href, obs_vs, obs_fs, obs_uf}, obs_data);
    end
    head = fifo_q[0][23:0];
    cycle(0, 1);
    total++;
    if ({obs_de, obs_data} !== {1'b1, head}) begin
      bad++; $display("FAIL rst_restart got=%b/%h exp=1/%h", obs_de, obs_data, head);
    end
  endtask

  task automatic test_back_to_back();
    int n_fs, n_pop, n_bad_fs;
    logic prev_vs;
    fresh();
    cycle(1, 1);
    n_fs = 0; n_pop = 0; n_bad_fs = 0; prev_vs = 1'b0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      cycle(0, 1);
      if (obs_fs) begin
        n_fs++;
        if (!(obs_vs && !prev_vs)) n_bad_fs++;
      end
      n_pop += int'(last_pop);
      prev_vs = obs_vs;
    end
    total++;
    if (n_fs != 2) begin bad++; $display("FAIL b2b_fs got=%0d exp=2", n_fs); end
    total++;
    if (n_bad_fs != 0) begin bad++; $display("FAIL b2b_fs_vsync got=%0d exp=0", n_bad_fs); end
    total++;
    if (n_pop != 2 * VA * HA / 4) begin bad++; $display("FAIL b2b_pops got=%0d exp=%0d", n_pop, 2 * VA * HA / 4); end
    total++;
    if (obs_uf !== 1'b0) begin bad++; $display("FAIL b2b_uf got=%b exp=0", obs_uf); end
  endtask

  initial begin
    @(posedge video_clk);
    #1;
    test_reset();
    test_known_word();
    test_raster();
    test_underflow();
    test_enable_stop();
    test_mid_reset();
    test_back_to_back();
    cycle(1, 0);
    @(negedge video_clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_out_timing.md
Name: video_out_timing

Overview:
- Downstream read-side output stage of the stitching pipeline.
- Consumes 128-bit words that the AXI read DMA has placed in a show-ahead (FWFT) read FIFO.
- Unpacks each word into four 24-bit pixels and drives the stitched 1280x720 raster on video_vsync/video_href/video_de/video_data.
- Emits a frame_start pulse so the read DMA can rewind its frame address and refill the FIFO ahead of the next active region.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (clocks)
- H_SYNC, 40, hsync width
- H_BP, 220, horizontal back porch
- V_ACTIVE, 720, active lines
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width
- V_BP, 20, vertical back porch
- FILL_COLOR, 24'h000000, pixel value driven on underflow
- DATA_WIDTH, 128, FIFO word width; fixed at 4 pixels per word

Ports:
- video_clk  in  1  pixel clock; only clock
- video_rst  in  1  synchronous, active-high reset
- enable  in  1  start/stop raster; sampled only at frame boundary
- fifo_rd_valid  in  1  FWFT FIFO has a word on fifo_rd_data
- fifo_rd_data  in  128  pixel i (0..3) in bits [32i+23:32i]; bits [32i+31:32i+24] ignored
- fifo_rd_en  out  1  pop current FIFO word
- frame_start  out  1  one-cycle pulse at vsync start
- video_vsync  out  1  vertical sync, active-high
- video_href  out  1  horizontal sync, active-high
- video_de  out  1  active video
- video_data  out  24  pixel; 0 when video_de=0
- underflow  out  1  sticky flag; cleared only by reset

Behaviour:
- Reset (video_rst=1 on a video_clk edge):
  - h_cnt=0, v_cnt=0, pix_sel=0, running=0.
  - All outputs 0, underflow=0.
- Start and stop:
  - With running=0, counters hold at 0 and outputs stay 0.
  - running loads enable only when h_cnt=0 and v_cnt=0, i.e. at frame boundaries; a mid-frame change of enable takes effect at the next boundary.
- Counters:
  - h_cnt counts 0..H_TOTAL-1 and wraps, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (1650).
  - v_cnt increments on each h wrap and wraps at V_TOTAL=750.
- Region decode from the counters (before registering):
  - h_de = h_cnt < H_ACTIVE.
  - hs = H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - v_de and vs decode the same way from v_cnt.
  - de_c = h_de & v_de & running.
- Outputs are registered with 1-cycle latency from the counters:
  - video_href = hs & running.
  - video_vsync = vs & running.
  - video_de = de_c.
- Pixel unpacking:
  - pix_sel (2 bits) advances on every de_c cycle and resets to 0 whenever de_c=0.
  - Each line (1280 px) therefore consumes exactly 320 words.
  - video_data (registered) = fifo_rd_data[32*pix_sel +: 24] when de_c and word_ok; FILL_COLOR when de_c and not word_ok; 0 otherwise.
- word_ok:
  - Register, evaluated at pix_sel=0 when de_c: word_ok = fifo_rd_valid.
  - Held for the remaining 3 pixels of the slot.
- Pop rule:
  - fifo_rd_en is combinational.
  - fifo_rd_en = de_c & pix_sel==3 & word_ok.
  - Exactly one pop per good 4-pixel slot; never pops when fifo_rd_valid=0.
- Underflow:
  - If fifo_rd_valid=0 at a pix_sel=0 slot start during de_c, the whole 4-pixel slot outputs FILL_COLOR with no pop and underflow sets.
  - Raster timing is never stalled.
  - A word arriving mid-slot is not used until the next slot boundary.
- frame_start:
  - 1-cycle pulse when running, h_cnt=0 and v_cnt=V_ACTIVE+V_FP; this is the registered cycle video_vsync rises.
  - Read DMA flushes and restarts on it, leaving V_SYNC+V_BP lines to prefill.
- Reset mid-frame: all state returns to reset values on the next edge, and any partially consumed word is abandoned (no pop).

Decomposition:
- Package video_out_pkg holds:
  - localparams H_TOTAL and V_TOTAL
  - localparam PIX_PER_WORD=4 and PIX_STRIDE=32
  - typedef pix_t (logic [23:0])
  - function region_decode(cnt, active, fp, sync) returning {de, sync}
- One sub-module is natural: video_timing_cnt, containing h/v counters and region decode, with outputs de_c, hs, vs and a sof strobe.
- The unpack/pop logic stays in the top module.

Test Plan:
- Reduced timing (H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1), enable=1 from reset, FIFO always valid with incrementing words -> 14-clock lines, 7-line frames, video_de high 8 clks/line, href high clks 10-11 (registered), 2 pops per line, pixels in order 0..3 per word.
- FIFO word 128'h..00_CCCCCC_00_BBBBBB_00_AAAAAA_00_999999 -> video_data sequence 999999, AAAAAA, BBBBBB, CCCCCC; fifo_rd_en high only on the 4th pixel.
- fifo_rd_valid=0 for the 2nd slot of line 0 -> 4 pixels of FILL_COLOR, no pop, underflow=1 and sticky.
- FIFO valid again from line 1 -> normal data resumes at the next slot.
- enable deasserted mid-frame -> frame completes; outputs all 0 from next boundary.
- Re-enabling -> raster restarts at h=0, v=0.
- frame_start pulses exactly once per frame, coincident with the video_vsync rising cycle.
- video_rst asserted mid-line for 1 clk -> all outputs 0 next cycle, no fifo_rd_en, counters restart from 0.
- Full 1280x720 default run for 2 frames, compared against video_to_pic capture -> 230400 pops per frame, underflow=0.
